// File: rtl/ctrl_estados_pkg.sv
// Shared constants, mode view and next-state helper for the state-register controller.
package ctrl_estados_pkg;

  localparam int unsigned EA_W = 3;

  localparam logic DIR_CIMA  = 1'b1;
  localparam logic DIR_BAIXO = 1'b0;

  localparam logic [EA_W-1:0] EA_RESET   = '0;
  localparam logic            SYNC_RESET = 1'b1;

  // Operating mode, derived combinationally from pausa/auto_en.
  typedef enum logic [1:0] {
    PARADO,
    MANUAL,
    AUTO
  } modo_e;

  // One step up or down with wrap at max_ea; states above max_ea never occur after reset.
  function automatic logic [EA_W-1:0] proximo_estado(input logic [EA_W-1:0] ea,
                                                     input logic            dir,
                                                     input logic [EA_W-1:0] max_ea);
    logic [EA_W-1:0] nxt;
    nxt = ea;
    case (dir)
      DIR_CIMA:  nxt = (ea == max_ea) ? EA_RESET : ea + 1'b1;
      DIR_BAIXO: nxt = (ea == EA_RESET) ? max_ea : ea - 1'b1;
    endcase
    return nxt;
  endfunction

endpackage

// File: rtl/ctrl_estados_if.sv
// Control inputs and state outputs between the controller and its environment.
interface ctrl_estados_if;
  import ctrl_estados_pkg::*;

  logic btn_avanca;
  logic dir;
  logic auto_en;
  logic pausa;
  logic ea2;
  logic ea1;
  logic ea0;
  logic passo;

  // Environment side: drives the controls, observes the state.
  modport master (
    output btn_avanca, dir, auto_en, pausa,
    input  ea2, ea1, ea0, passo
  );

  // Controller side.
  modport slave (
    input  btn_avanca, dir, auto_en, pausa,
    output ea2, ea1, ea0, passo
  );

endinterface

// File: rtl/sincroniza_borda.sv
// Two-flop synchroniser plus rising-edge detector for the asynchronous advance button.
module sincroniza_borda
  import ctrl_estados_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic i_async,
  output logic o_borda
);

  logic r_s1;
  logic r_s2;
  logic r_prev;

  // Flops preset to 1 so a button held across reset release is not seen as a new press.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_s1   <= SYNC_RESET;
      r_s2   <= SYNC_RESET;
      r_prev <= SYNC_RESET;
    end else begin
      r_s1   <= i_async;
      r_s2   <= r_s1;
      r_prev <= r_s2;
    end
  end

  assign o_borda = r_s2 & ~r_prev;

endmodule

// File: rtl/ctrl_estados.sv
// Current-state register for the 7-segment decoder, stepped by button or auto timer.
module ctrl_estados
  import ctrl_estados_pkg::*;
#(
  parameter int unsigned TICK_DIV   = 4,
  parameter int unsigned MAX_ESTADO = 7
) (
  input  logic           clk,
  input  logic           rst_n,
  ctrl_estados_if.slave  bus
);

  localparam int unsigned     CNT_W   = $clog2(TICK_DIV);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TICK_DIV - 1);
  localparam logic [EA_W-1:0]  EA_MAX  = EA_W'(MAX_ESTADO);

  logic [CNT_W-1:0] r_cnt;
  logic [EA_W-1:0]  r_ea;
  logic             r_passo;

  logic  w_req_man;
  logic  w_req_auto;
  logic  w_step;
  modo_e w_modo;

  sincroniza_borda u_sincroniza_borda (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_async (bus.btn_avanca),
    .o_borda (w_req_man)
  );

  // Mode view: pause dominates, otherwise auto_en selects auto vs manual.
  always_comb begin
    w_modo = MANUAL;
    if (bus.pausa) begin
      w_modo = PARADO;
    end else if (bus.auto_en) begin
      w_modo = AUTO;
    end
  end

  assign w_req_auto = (w_modo == AUTO) && (r_cnt == CNT_MAX);
  // Manual and auto requests merge into a single step; paused requests are dropped.
  assign w_step     = (w_req_man | w_req_auto) & ~bus.pausa;

  // Auto-step timer: clears when disabled, holds while paused, wraps on its request.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (!bus.auto_en) begin
      r_cnt <= '0;
    end else if (w_modo == AUTO) begin
      r_cnt <= w_req_auto ? '0 : r_cnt + 1'b1;
    end
  end

  // State register and step pulse; passo is aligned with the updated state.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_ea    <= EA_RESET;
      r_passo <= 1'b0;
    end else begin
      r_passo <= w_step;
      if (w_step) begin
        r_ea <= proximo_estado(r_ea, bus.dir, EA_MAX);
      end
    end
  end

  assign bus.ea2   = r_ea[2];
  assign bus.ea1   = r_ea[1];
  assign bus.ea0   = r_ea[0];
  assign bus.passo = r_passo;

  a_pausa_bloqueia: assert property (@(posedge clk) disable iff (!rst_n)
    (w_modo == PARADO) |=> !r_passo);

  a_ea_limite: assert property (@(posedge clk) disable iff (!rst_n) r_ea <= EA_MAX);

endmodule

// File: tb/tb_ctrl_estados.sv
// Bench for ctrl_estados: two instances (wrap at 7 and at 5) driven in lockstep.
module tb_ctrl_estados;
  import ctrl_estados_pkg::*;

  logic clk = 1'b0;
  logic rst_n;

  always #5 clk = ~clk;

  ctrl_estados_if bus7 ();
  ctrl_estados_if bus5 ();

  ctrl_estados #(.TICK_DIV(4), .MAX_ESTADO(7)) u_dut7 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus7)
  );

  ctrl_estados #(.TICK_DIV(4), .MAX_ESTADO(5)) u_dut5 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus5)
  );

  typedef struct {
    logic       rst_n;
    logic       btn;
    logic       dir;
    logic       auto_en;
    logic       pausa;
    logic [2:0] ea7;
    logic [2:0] ea5;
    logic       passo;
    int         ph;
  } vec_t;

  typedef struct {
    logic [2:0] ea7;
    logic [2:0] ea5;
    logic       passo;
    int         ph;
    int         idx;
  } exp_t;

  vec_t  tbl[$];
  exp_t  sb_q[$];
  int    n_vec = 0;
  int    n_cmp = 0;
  int    n_err = 0;
  logic [2:0] m7;
  logic [2:0] m5;

  string ph_name [6] = '{"reset_hold", "up_wrap", "down_wrap", "auto", "collision", "mid_reset"};

  function automatic vec_t mk(input logic r, input logic b, input logic d, input logic a,
                              input logic p, input logic [2:0] e7, input logic [2:0] e5,
                              input logic ps, input int ph);
    vec_t v;
    v.rst_n = r; v.btn = b; v.dir = d; v.auto_en = a; v.pausa = p;
    v.ea7 = e7; v.ea5 = e5; v.passo = ps; v.ph = ph;
    return v;
  endfunction

  task automatic add(input logic r, input logic b, input logic d, input logic a, input logic p,
                     input logic [2:0] e7, input logic [2:0] e5, input logic ps, input int ph);
    tbl.push_back(mk(r, b, d, a, p, e7, e5, ps, ph));
  endtask

  // One isolated press: two idle cycles, one high cycle, state changes two edges later.
  task automatic press(input logic d, input int ph);
    logic [2:0] n7;
    logic [2:0] n5;
    if (d) begin
      n7 = (m7 == 3'd7) ? 3'd0 : m7 + 3'd1;
      n5 = (m5 == 3'd5) ? 3'd0 : m5 + 3'd1;
    end else begin
      n7 = (m7 == 3'd0) ? 3'd7 : m7 - 3'd1;
      n5 = (m5 == 3'd0) ? 3'd5 : m5 - 3'd1;
    end
    add(1, 0, d, 0, 0, m7, m5, 0, ph);
    add(1, 0, d, 0, 0, m7, m5, 0, ph);
    add(1, 1, d, 0, 0, m7, m5, 0, ph);
    add(1, 0, d, 0, 0, m7, m5, 0, ph);
    add(1, 0, d, 0, 0, n7, n5, 1, ph);
    add(1, 0, d, 0, 0, n7, n5, 0, ph);
    m7 = n7;
    m5 = n5;
  endtask

  task automatic chk(input string what, input exp_t e, input logic [2:0] got,
                     input logic [2:0] want);
    n_cmp++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s %s vec %0d: got %0d, want %0d", ph_name[e.ph], what, e.idx, got, want);
    end
  endtask

  // Drive one cycle of stimulus, queue its expectation, compare after the edge.
  task automatic apply(input vec_t v);
    exp_t e;
    exp_t o;
    rst_n           = v.rst_n;
    bus7.btn_avanca = v.btn;  bus5.btn_avanca = v.btn;
    bus7.dir        = v.dir;  bus5.dir        = v.dir;
    bus7.auto_en    = v.auto_en; bus5.auto_en = v.auto_en;
    bus7.pausa      = v.pausa; bus5.pausa     = v.pausa;
    e.ea7 = v.ea7; e.ea5 = v.ea5; e.passo = v.passo; e.ph = v.ph; e.idx = n_vec;
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    o = sb_q.pop_front();
    chk("ea7", o, {bus7.ea2, bus7.ea1, bus7.ea0}, o.ea7);
    chk("ea5", o, {bus5.ea2, bus5.ea1, bus5.ea0}, o.ea5);
    chk("passo7", o, {2'b00, bus7.passo}, {2'b00, o.passo});
    chk("passo5", o, {2'b00, bus5.passo}, {2'b00, o.passo});
    n_vec++;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish, vectors %0d", n_vec);
    $fatal(1, "watchdog");
  end

  initial begin
    m7 = 3'd0;
    m5 = 3'd0;

    // Button held through reset and after release: no step until a fresh press.
    repeat (2)  add(0, 1, 1, 0, 0, 0, 0, 0, 0);
    repeat (10) add(1, 1, 1, 0, 0, 0, 0, 0, 0);
    repeat (3)  add(1, 0, 1, 0, 0, 0, 0, 0, 0);
    press(1, 0);

    // Up count through the wrap point of both instances.
    repeat (2) add(0, 0, 1, 0, 0, 0, 0, 0, 1);
    m7 = 3'd0; m5 = 3'd0;
    repeat (8) press(1, 1);

    // Down count from 0 wraps to the maximum.
    repeat (2) add(0, 0, 0, 0, 0, 0, 0, 0, 2);
    m7 = 3'd0; m5 = 3'd0;
    press(0, 2);
    press(0, 2);

    for (int i = 0; i < tbl.size(); i++) begin
      apply(tbl[i]);
    end

    // Auto stepping every 4 edges from reset.
    repeat (2) apply(mk(0, 0, 1, 1, 0, 0, 0, 0, 3));
    for (int i = 1; i <= 12; i++) begin
      apply(mk(1, 0, 1, 1, 0, 3'(i / 4), 3'(i / 4), (i % 4) == 0, 3));
    end
    apply(mk(1, 0, 1, 1, 0, 3, 3, 0, 3));
    // Pause with the timer at 1: it must hold and resume from there.
    repeat (6) apply(mk(1, 0, 1, 1, 1, 3, 3, 0, 3));
    apply(mk(1, 0, 1, 1, 0, 3, 3, 0, 3));
    apply(mk(1, 0, 1, 1, 0, 3, 3, 0, 3));
    apply(mk(1, 0, 1, 1, 0, 4, 4, 1, 3));

    // Manual request lands in the same cycle as the auto request: one step only.
    apply(mk(1, 0, 1, 1, 0, 4, 4, 0, 4));
    apply(mk(1, 1, 1, 1, 0, 4, 4, 0, 4));
    apply(mk(1, 0, 1, 1, 0, 4, 4, 0, 4));
    apply(mk(1, 0, 1, 1, 0, 5, 5, 1, 4));
    apply(mk(1, 0, 1, 1, 0, 5, 5, 0, 4));
    // Press during pause is dropped, not replayed when pause ends.
    apply(mk(1, 1, 1, 0, 1, 5, 5, 0, 4));
    repeat (3) apply(mk(1, 0, 1, 0, 1, 5, 5, 0, 4));
    repeat (4) apply(mk(1, 0, 1, 0, 0, 5, 5, 0, 4));

    // Reach ea=6, then reset on the edge where a manual step is due.
    apply(mk(1, 1, 1, 0, 0, 5, 5, 0, 5));
    apply(mk(1, 0, 1, 0, 0, 5, 5, 0, 5));
    apply(mk(1, 0, 1, 0, 0, 6, 0, 1, 5));
    apply(mk(1, 0, 1, 0, 0, 6, 0, 0, 5));
    apply(mk(1, 1, 1, 1, 0, 6, 0, 0, 5));
    apply(mk(1, 0, 1, 1, 0, 6, 0, 0, 5));
    apply(mk(0, 0, 1, 1, 0, 0, 0, 0, 5));
    // Timer restarted from 0: first auto step on the fourth edge.
    repeat (3) apply(mk(1, 0, 1, 1, 0, 0, 0, 0, 5));
    apply(mk(1, 0, 1, 1, 0, 1, 1, 1, 5));
    apply(mk(1, 0, 1, 1, 0, 1, 1, 0, 5));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/ctrl_estados.md
Name: ctrl_estados

Overview:
- Upstream neighbour of the 7-segment output decoder: holds the 3-bit current-state register and drives ea2..ea0 straight into it.
- Advances the state on a manual button press (synchronised, edge-detected) or on an auto-step timer.
- Supports up/down direction, a pause input and a configurable wrap point.
- Purely sequential control. The downstream decoder stays combinational.

Parameters:
- TICK_DIV, 4: clock cycles per automatic step. Legal range ≥2.
- MAX_ESTADO, 7: highest state value; the counter wraps here. Legal range 1..7.

Ports:
- clk  in  1  single system clock, rising edge.
- rst_n  in  1  synchronous reset, active-low.
- btn_avanca  in  1  raw manual-advance button; asynchronous to clk.
- dir  in  1  1 = count up, 0 = count down; sampled on the step cycle.
- auto_en  in  1  enables the automatic step timer.
- pausa  in  1  blocks all steps while high.
- ea2  out  1  current state bit 2 (MSB).
- ea1  out  1  current state bit 1.
- ea0  out  1  current state bit 0 (LSB).
- passo  out  1  one-cycle pulse, registered, coincident with each state update.

Behaviour:
- Reset: rst_n sampled low at a clk edge gives:
  - {ea2,ea1,ea0}=0, passo=0, tick counter=0;
  - synchroniser flops s1=s2=1 and edge-history flop prev=1.
  - Presetting s1/s2/prev to 1 means a button held across reset release causes no step.
- Reset mid-operation overrides everything in that cycle, including any pending step.
- Button path:
  - btn_avanca passes through the two-flop synchroniser s1→s2.
  - prev<=s2 every cycle.
  - req_man = s2 & ~prev.
  - Latency: btn first sampled high at edge k → ea updates at edge k+2 and passo=1 for the cycle after edge k+2.
- Tick counter:
  - Counts 0..TICK_DIV-1 while auto_en=1 and pausa=0.
  - Holds its value while pausa=1.
  - Clears to 0 whenever auto_en=0.
  - req_auto=1 in the cycle where count==TICK_DIV-1 (with auto_en=1, pausa=0); the counter wraps to 0 on that edge.
- Step rule:
  - step = (req_man | req_auto) & ~pausa.
  - Simultaneous manual and auto requests produce exactly ONE step.
  - A manual edge arriving while pausa=1 is discarded, not queued.
- On step, computed in EA_W bits:
  - dir=1: ea = (ea==MAX_ESTADO) ? 0 : ea+1.
  - dir=0: ea = (ea==0) ? MAX_ESTADO : ea-1.
  - States above MAX_ESTADO are unreachable after reset.
- passo is registered: it equals step, aligned with the new ea value.
- With no step, ea and passo=0 hold.
- Mode view, for documentation and assertions:
  - PARADO: pausa=1.
  - MANUAL: auto_en=0.
  - AUTO: auto_en=1.
  - Transitions follow the inputs combinationally; no extra latency.

Decomposition:
- Package ctrl_estados_pkg holds:
  - EA_W=3;
  - DIR_CIMA=1, DIR_BAIXO=0;
  - reset constants: EA_RESET=0, SYNC_RESET=1.
- Sub-module sincroniza_borda contains the two-flop synchroniser, the prev flop and the rising-edge output.
  - Parameterless; its own clk and rst_n; reset value 1 on all three flops.
- Top level holds the tick counter, step arbitration and the state register.

Test Plan:
- Reset/hold: btn_avanca=1 through reset, release rst_n → ea stays 0 and passo stays 0 for 10 cycles. Then release btn and press again → ea=1 exactly 2 edges after sampling, passo pulse width exactly 1 cycle.
- Up wrap: dir=1, MAX_ESTADO=7, 8 manual presses → ea sequence 1,2,3,4,5,6,7,0, one passo per press.
- Down wrap: MAX_ESTADO=5, start ea=0, dir=0, one press → ea=5; next press → ea=4.
- Auto timing: TICK_DIV=4, auto_en=1 held for 12 cycles from reset → ea=1,2,3 at cycles 4, 8, 12.
  - Then pausa=1 for 6 cycles → no change and counter holds.
  - Release pausa → next step exactly at the remaining count.
- Collision: manual edge timed into the same cycle as req_auto → ea advances by 1 only, single passo. A manual edge during pausa=1 → no step after pausa drops.
- Mid-run reset: rst_n=0 for 1 edge while ea=6 and a step is pending → ea=0, counter=0, no passo.
